// File: rtl/alu_divider.sv
// alu_divider: sequential restoring divider with valid/ready handshakes.
// The divider works on operand magnitudes, producing one quotient bit per cycle,
// and applies the sign corrections in a dedicated FIXUP cycle.
// Optional feature macro: ALU_DIV_EARLY_OUT_EN. When it is defined, an operation
// that cannot produce a non-zero quotient skips the iteration phase.
module alu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] FIXUP = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

`ifdef ALU_DIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;       // partial remainder (magnitude)
  logic [WIDTH-1:0] quo_q, quo_d;       // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;       // divisor magnitude
  logic [WIDTH-1:0] dvd_q, dvd_d;       // raw dividend, returned on divide-by-zero
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             zero_dvs_q, zero_dvs_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic             early_out;
  logic [WIDTH:0]   shifted, trial;
  logic             fits;

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

  // Operand conditioning: signs, magnitudes and the early-out decision.
  always_comb begin
    dvd_neg   = req_signed & dividend[WIDTH-1];
    dvs_neg   = req_signed & divisor[WIDTH-1];
    dvd_mag   = dvd_neg ? -dividend : dividend;
    dvs_mag   = dvs_neg ? -divisor : divisor;
    early_out = EARLY_OUT && ((divisor == '0) || (dvd_mag < dvs_mag));
  end

  // One restoring step: shift in the next dividend bit and try to subtract.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    fits    = (shifted >= {1'b0, dvs_q});
    trial   = shifted - {1'b0, dvs_q};
  end

  // Control FSM and datapath next-state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    dvs_d         = dvs_q;
    dvd_d         = dvd_q;
    neg_quo_d     = neg_quo_q;
    neg_rem_d     = neg_rem_q;
    zero_dvs_d    = zero_dvs_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          dvs_d      = dvs_mag;
          dvd_d      = dividend;
          neg_quo_d  = dvd_neg ^ dvs_neg;
          neg_rem_d  = dvd_neg;
          zero_dvs_d = (divisor == '0);
          cnt_d      = CNT_W'(WIDTH - 1);
          if (early_out) begin
            // Quotient is known to be zero; the remainder is the dividend itself.
            rem_d   = dvd_mag;
            quo_d   = '0;
            state_d = FIXUP;
          end else begin
            rem_d   = '0;
            quo_d   = dvd_mag;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        rem_d = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], fits};
        if (cnt_q == '0) begin
          state_d = FIXUP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FIXUP: begin
        // Divide-by-zero results override whatever the iteration produced.
        if (zero_dvs_q) begin
          quotient_d  = '1;
          remainder_d = dvd_q;
        end else begin
          quotient_d  = neg_quo_q ? -quo_q : quo_q;
          remainder_d = neg_rem_q ? -rem_q : rem_q;
        end
        div_by_zero_d = zero_dvs_q;
        state_d       = DONE;
      end
      DONE: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any operation and clears the result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvs_q         <= '0;
      dvd_q         <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      zero_dvs_q    <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      dvs_q         <= dvs_d;
      dvd_q         <= dvd_d;
      neg_quo_q     <= neg_quo_d;
      neg_rem_q     <= neg_rem_d;
      zero_dvs_q    <= zero_dvs_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

endmodule

// File: doc/alu_divider.md
ALU_DIVIDER -- requirements
Module: alu_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result bit width (legal range 4..64).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  request operands valid.
REQ-005 SHALL have port req_ready  output  1  divider can accept a request.
REQ-006 SHALL have port req_signed  input  1  1 = two's-complement operation, 0 = unsigned.
REQ-007 SHALL have port dividend  input  WIDTH  numerator.
REQ-008 SHALL have port divisor  input  WIDTH  denominator.
REQ-009 SHALL have port resp_valid  output  1  result valid.
REQ-010 SHALL have port resp_ready  input  1  consumer accepts result.
REQ-011 SHALL have port quotient  output  WIDTH  result quotient.
REQ-012 SHALL have port remainder  output  WIDTH  result remainder.
REQ-013 SHALL have port div_by_zero  output  1  flag: divisor was zero.

Function
REQ-014 SHALL implement states IDLE, BUSY, FIXUP, DONE.
REQ-015 SHALL drive req_ready=1 only in IDLE; a request is accepted on a rising edge with req_valid&&req_ready, capturing operands and req_signed; IDLE->BUSY.
REQ-016 SHALL in BUSY perform restoring division on operand magnitudes, one quotient bit per cycle, MSB first, for exactly WIDTH cycles, then BUSY->FIXUP.
REQ-017 SHALL in FIXUP (one cycle) negate quotient if signed and operand signs differ, negate remainder if signed and dividend negative; FIXUP->DONE.
REQ-018 SHALL assert resp_valid only in DONE, WIDTH+2 cycles after the accepting edge; results stable while resp_valid=1.
REQ-019 SHALL leave DONE to IDLE on the edge with resp_valid&&resp_ready; req_ready rises the following cycle (no same-cycle accept/respond).
REQ-020 SHALL, when divisor=0, return quotient all-ones, remainder=original dividend, div_by_zero=1, regardless of req_signed.
REQ-021 SHALL, for signed most-negative / -1, return quotient=dividend (most-negative), remainder=0, div_by_zero=0.
REQ-022 SHALL hold div_by_zero=0 for all nonzero divisors; remainder sign matches dividend sign (truncating division).
REQ-023 SHALL ignore req_valid, dividend, divisor, req_signed changes outside IDLE.

Reset
REQ-024 SHALL, when rst=1 at a rising edge, go to IDLE from any state, aborting any in-flight operation with no response produced.
REQ-025 SHALL reset outputs to req_ready=0 during rst=1 cycle's registered state, then req_ready=1, resp_valid=0, quotient=0, remainder=0, div_by_zero=0 from the first edge with rst=1 onward.
REQ-026 SHALL give rst priority over every handshake event on the same edge.

Configuration
REQ-027 SHALL provide macro ALU_DIV_EARLY_OUT_EN.
REQ-028 SHALL, with ALU_DIV_EARLY_OUT_EN defined, skip BUSY (IDLE->FIXUP) when divisor=0 or |dividend|<|divisor|, giving resp_valid 2 cycles after accept with identical results.
REQ-029 SHALL, without ALU_DIV_EARLY_OUT_EN, use fixed WIDTH+2 latency for every operation.

Verification (WIDTH=8)
REQ-030 SHALL cover unsigned 200/7 -> quotient=28, remainder=4, div_by_zero=0, resp_valid exactly 10 cycles after accept.
REQ-031 SHALL cover signed -100/7 (0x9C/0x07) -> quotient=-14 (0xF2), remainder=-2 (0xFE).
REQ-032 SHALL cover signed 0x80/0xFF -> quotient=0x80, remainder=0x00; and 0x2A/0x00 -> quotient=0xFF, remainder=0x2A, div_by_zero=1.
REQ-033 SHALL cover resp_ready held low 5 cycles in DONE -> resp_valid and results stable, req_ready=0 until cycle after handshake.
REQ-034 SHALL cover rst=1 at 4th BUSY cycle -> next cycle IDLE, req_ready=1, resp_valid never asserted for aborted request.
REQ-035 SHALL cover, with ALU_DIV_EARLY_OUT_EN, unsigned 3/9 -> quotient=0, remainder=3, resp_valid 2 cycles after accept; without macro, 10 cycles.
